// File: rtl/toomcook_arbiter.sv
// Round-robin front end that shares one toomcook multiplier among NUM_REQ clients.
// An in-order tag FIFO routes each result back to the requester that issued it.
module toomcook_arbiter #(
   parameter int WIDTH     = 32,
   parameter int NUM_REQ   = 4,
   parameter int TAG_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]       req_a,
   input  logic [NUM_REQ*WIDTH-1:0]       req_b,
   output logic [NUM_REQ-1:0]             req_ack,
   output logic [NUM_REQ-1:0]             rsp_valid,
   input  logic [NUM_REQ-1:0]             rsp_release,
   output logic [2*WIDTH-1:0]             rsp_result,
   output logic                           mul_new_data,
   input  logic                           mul_ack_data,
   output logic [WIDTH-1:0]               mul_a,
   output logic [WIDTH-1:0]               mul_b,
   input  logic                           mul_valid,
   output logic                           mul_release,
   input  logic [2*WIDTH-1:0]             mul_result,
   output logic [$clog2(TAG_DEPTH+1)-1:0] inflight,
   output logic                           err_orphan
);

   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CNT_W = $clog2(TAG_DEPTH + 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_e;

   // Pointers wrap explicitly so non-power-of-two depths behave.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(TAG_DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   state_e                  state_q, state_d;
   logic [ID_W-1:0]         last_q, last_d;
   logic [ID_W-1:0]         hold_id_q, hold_id_d;
   logic [WIDTH-1:0]        mul_a_q, mul_a_d;
   logic [WIDTH-1:0]        mul_b_q, mul_b_d;
   logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
   logic [ID_W-1:0]         tag_mem_q [TAG_DEPTH];
   logic [ID_W-1:0]         tag_mem_d [TAG_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    err_q, err_d;

   logic [WIDTH-1:0]        a_slice_s [NUM_REQ];
   logic [WIDTH-1:0]        b_slice_s [NUM_REQ];
   logic                    win_found_s;
   logic [ID_W-1:0]         win_id_s;
   logic [ID_W-1:0]         scan_idx_s;
   logic [CNT_W-1:0]        inflight_s;
   logic                    admit_s;
   logic                    push_s;
   logic                    pop_s;
   logic [ID_W-1:0]         head_id_s;
   logic                    fifo_empty_s;
   logic [NUM_REQ-1:0]      rsp_valid_s;
   logic                    mul_release_s;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign a_slice_s[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_slice_s[gi] = req_b[gi*WIDTH +: WIDTH];
   end

   assign inflight_s   = count_q + CNT_W'(state_q == ST_ISSUE);
   assign fifo_empty_s = (count_q == '0);
   assign head_id_s    = tag_mem_q[rd_ptr_q];
   assign admit_s      = win_found_s && (inflight_s < CNT_W'(TAG_DEPTH));

   // Round-robin pick: first requester after the last winner, wrapping.
   always_comb begin
      win_found_s = 1'b0;
      win_id_s    = '0;
      scan_idx_s  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx_s = ID_W'((int'(last_q) + k) % NUM_REQ);
         if (!win_found_s && req_valid[scan_idx_s]) begin
            win_found_s = 1'b1;
            win_id_s    = scan_idx_s;
         end else begin
            win_id_s    = win_id_s;
         end
      end
   end

   // Issue FSM: admit in IDLE, hold operands in ISSUE until the multiplier acks.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      hold_id_d = hold_id_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      req_ack_d = '0;
      push_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (admit_s) begin
               mul_a_d             = a_slice_s[win_id_s];
               mul_b_d             = b_slice_s[win_id_s];
               req_ack_d[win_id_s] = 1'b1;
               hold_id_d           = win_id_s;
               last_d              = win_id_s;
               state_d             = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (mul_ack_data) begin
               push_s  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Return path: route the head result to its owner; drain untagged results.
   always_comb begin
      rsp_valid_s   = '0;
      mul_release_s = 1'b0;
      pop_s         = 1'b0;
      err_d         = err_q;
      if (mul_valid) begin
         if (!fifo_empty_s) begin
            rsp_valid_s[head_id_s] = 1'b1;
            mul_release_s          = rsp_release[head_id_s];
            pop_s                  = rsp_release[head_id_s];
         end else begin
            mul_release_s = 1'b1;
            err_d         = 1'b1;
         end
      end else begin
         err_d = err_q;
      end
   end

   // Tag FIFO bookkeeping; push and pop in one cycle leave the count unchanged.
   always_comb begin
      tag_mem_d = tag_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_s) begin
         tag_mem_d[wr_ptr_q] = hold_id_q;
         wr_ptr_d            = ptr_next(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_s && !push_s) begin
         count_d = count_q - CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         last_q    <= ID_W'(NUM_REQ - 1);
         hold_id_q <= '0;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         req_ack_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
         for (int i = 0; i < TAG_DEPTH; i++) begin
            tag_mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         hold_id_q <= hold_id_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         req_ack_q <= req_ack_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_q     <= err_d;
         tag_mem_q <= tag_mem_d;
      end
   end

   assign req_ack      = req_ack_q;
   assign mul_new_data = (state_q == ST_ISSUE);
   assign mul_a        = mul_a_q;
   assign mul_b        = mul_b_q;
   assign inflight     = inflight_s;
   assign err_orphan   = err_q;
   assign rsp_valid    = rsp_valid_s;
   assign mul_release  = mul_release_s;
   assign rsp_result   = mul_result;

endmodule

// File: tb/tb_toomcook_arbiter.sv
// Bench for toomcook_arbiter: queue-based reference model plus a stand-in in-order
// multiplier; directed scenarios add literal expectations.
module tb_toomcook_arbiter;
   localparam int W  = 32;
   localparam int N  = 4;
   localparam int TD = 4;
   localparam int CW = $clog2(TD + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*W-1:0]    req_a, req_b;
   logic [N-1:0]      req_ack, rsp_valid, rsp_release;
   logic [2*W-1:0]    rsp_result, mul_result;
   logic              mul_new_data, mul_ack_data, mul_valid, mul_release;
   logic [W-1:0]      mul_a, mul_b;
   logic [CW-1:0]     inflight;
   logic              err_orphan;

   logic              ack_en, out_en, force_orphan;
   logic              mq_vld = 1'b0;
   logic [2*W-1:0]    mq_head = '0;
   logic [2*W-1:0]    mq[$];

   int checks = 0;
   int passes = 0;

   toomcook_arbiter #(.WIDTH(W), .NUM_REQ(N), .TAG_DEPTH(TD)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_release(rsp_release),
      .rsp_result(rsp_result), .mul_new_data(mul_new_data), .mul_ack_data(mul_ack_data),
      .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid), .mul_release(mul_release),
      .mul_result(mul_result), .inflight(inflight), .err_orphan(err_orphan)
   );

   always #5 clk = ~clk;

   assign mul_ack_data = ack_en;
   assign mul_valid    = force_orphan | (out_en & mq_vld);
   assign mul_result   = mq_vld ? mq_head : '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model state
   bit             m_valid = 1'b0;
   int             m_last;
   bit             m_busy;
   int             m_busy_id;
   logic [W-1:0]   m_a, m_b;
   logic [N-1:0]   m_ack;
   int             m_tags[$];
   bit             m_err;
   logic [N-1:0]   e_rv;
   logic           e_rel;
   int             idx, win, pre_inf;
   bit             do_pop, do_push, do_admit;
   logic signed [2*W-1:0] ea, eb;

   // Multiplier output side updates just after each rising edge.
   always @(posedge clk) begin
      #1;
      mq_vld  = (mq.size() > 0);
      mq_head = mq_vld ? mq[0] : '0;
   end

   // Compare against the model mid-cycle, then advance model and multiplier.
   always @(negedge clk) begin
      if (m_valid) begin
         e_rv  = '0;
         e_rel = 1'b0;
         if (mul_valid) begin
            if (m_tags.size() > 0) begin
               e_rv[m_tags[0]] = 1'b1;
               e_rel = rsp_release[m_tags[0]];
            end else begin
               e_rel = 1'b1;
            end
         end
         chk("inflight", 64'(inflight), 64'(m_tags.size() + int'(m_busy)));
         chk("mul_new_data", 64'(mul_new_data), 64'(m_busy));
         chk("mul_a", 64'(mul_a), 64'(m_a));
         chk("mul_b", 64'(mul_b), 64'(m_b));
         chk("req_ack", 64'(req_ack), 64'(m_ack));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
         chk("mul_release", 64'(mul_release), 64'(e_rel));
         chk("rsp_result", rsp_result, mul_result);
         chk("err_orphan", 64'(err_orphan), 64'(m_err));
      end
      if (rst) begin
         m_valid = 1'b1; m_last = N - 1; m_busy = 1'b0; m_busy_id = 0;
         m_a = '0; m_b = '0; m_ack = '0; m_err = 1'b0;
         m_tags.delete();
         mq.delete();
      end else if (m_valid) begin
         pre_inf  = m_tags.size() + int'(m_busy);
         do_pop   = mul_valid && (m_tags.size() > 0) && rsp_release[m_tags[0]];
         if (mul_valid && m_tags.size() == 0) m_err = 1'b1;
         do_push  = m_busy && mul_ack_data;
         do_admit = !m_busy && (req_valid != '0) && (pre_inf < TD);
         if (mul_valid && mul_release && mq.size() > 0) void'(mq.pop_front());
         if (mul_new_data && mul_ack_data) begin
            ea = $signed({{W{mul_a[W-1]}}, mul_a});
            eb = $signed({{W{mul_b[W-1]}}, mul_b});
            mq.push_back(ea * eb);
         end
         if (do_pop) void'(m_tags.pop_front());
         if (do_push) begin
            m_tags.push_back(m_busy_id);
            m_busy = 1'b0;
         end
         m_ack = '0;
         if (do_admit) begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
               idx = (m_last + k) % N;
               if (win < 0 && req_valid[idx]) win = idx;
            end
            m_a = req_a[win*W +: W];
            m_b = req_b[win*W +: W];
            m_ack[win] = 1'b1;
            m_busy = 1'b1;
            m_busy_id = win;
            m_last = win;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = '0; rsp_release = '0;
      ack_en = 1'b1; out_en = 1'b1; force_orphan = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   int grants[$];

   initial begin
      req_a = '0; req_b = '0;
      rst = 1'b1; req_valid = '0; rsp_release = '0;
      ack_en = 1'b1; out_en = 1'b1; force_orphan = 1'b0;

      // 1: single op, 7 * -3
      do_reset();
      set_op(0, 32'd7, 32'hFFFF_FFFD); req_valid = 4'b0001; ack_en = 1'b0;
      @(negedge clk);
      chk("t1_reset_inflight", 64'(inflight), 64'd0);
      chk("t1_reset_newdata", 64'(mul_new_data), 64'd0);
      chk("t1_reset_ack", 64'(req_ack), 64'd0);
      tick(); req_valid = '0;
      @(negedge clk);
      chk("t1_ack", 64'(req_ack), 64'b0001);
      chk("t1_newdata", 64'(mul_new_data), 64'd1);
      chk("t1_mul_a", 64'(mul_a), 64'd7);
      tick(); ack_en = 1'b1;
      @(negedge clk);
      chk("t1_ack_pulse", 64'(req_ack), 64'd0);
      chk("t1_newdata_hold", 64'(mul_new_data), 64'd1);
      tick(); rsp_release = 4'b0001;
      @(negedge clk);
      chk("t1_newdata_off", 64'(mul_new_data), 64'd0);
      chk("t1_rsp_valid", 64'(rsp_valid), 64'b0001);
      chk("t1_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFEB);
      chk("t1_release", 64'(mul_release), 64'd1);
      tick(); rsp_release = '0;
      @(negedge clk);
      chk("t1_inflight_end", 64'(inflight), 64'd0);

      // 2: fairness with all four requesting
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, W'(i + 1), 32'd10);
      req_valid = 4'b1111; rsp_release = 4'b1111;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (req_ack != '0) grants.push_back(onehot_idx(req_ack));
      end
      chk("t2_ngrants", 64'(grants.size() >= 5), 64'd1);
      if (grants.size() >= 5) begin
         chk("t2_g0", 64'(grants[0]), 64'd0);
         chk("t2_g1", 64'(grants[1]), 64'd1);
         chk("t2_g2", 64'(grants[2]), 64'd2);
         chk("t2_g3", 64'(grants[3]), 64'd3);
         chk("t2_g4", 64'(grants[4]), 64'd0);
      end
      for (int j = 1; j < grants.size(); j++)
         chk("t2_no_repeat", 64'(grants[j] != grants[j-1]), 64'd1);

      // 3: full pipeline blocks admission until a release
      do_reset();
      req_valid = 4'b1111; out_en = 1'b0;
      for (int c = 0; c < 12; c++) tick();
      @(negedge clk);
      chk("t3_inflight_full", 64'(inflight), 64'd4);
      chk("t3_no_ack", 64'(req_ack), 64'd0);
      chk("t3_no_newdata", 64'(mul_new_data), 64'd0);
      tick(); out_en = 1'b1; rsp_release = 4'b0001;
      @(negedge clk);
      chk("t3_head", 64'(rsp_valid), 64'b0001);
      tick(); out_en = 1'b0; rsp_release = '0;
      @(negedge clk);
      chk("t3_inflight_3", 64'(inflight), 64'd3);
      tick();
      @(negedge clk);
      chk("t3_readmit", 64'(req_ack), 64'b0001);
      chk("t3_inflight_4", 64'(inflight), 64'd4);

      // 4: routing back to owners in issue order
      do_reset();
      out_en = 1'b0; set_op(2, 32'd5, 32'd6); req_valid = 4'b0100;
      tick(); req_valid = 4'b0010; set_op(1, 32'd3, 32'd3);
      @(negedge clk);
      chk("t4_ack2", 64'(req_ack), 64'b0100);
      tick(); tick(); req_valid = '0;
      @(negedge clk);
      chk("t4_ack1", 64'(req_ack), 64'b0010);
      tick(); out_en = 1'b1; rsp_release = 4'b0010;
      @(negedge clk);
      chk("t4_rv_first", 64'(rsp_valid), 64'b0100);
      chk("t4_res_first", rsp_result, 64'd30);
      chk("t4_nonhead_rel", 64'(mul_release), 64'd0);
      tick();
      @(negedge clk);
      chk("t4_no_pop", 64'(inflight), 64'd2);
      tick(); rsp_release = 4'b0100;
      tick(); rsp_release = '0;
      @(negedge clk);
      chk("t4_rv_second", 64'(rsp_valid), 64'b0010);
      chk("t4_res_second", rsp_result, 64'd9);
      tick(); rsp_release = 4'b0010;
      tick(); rsp_release = '0;
      @(negedge clk);
      chk("t4_drained", 64'(inflight), 64'd0);

      // 5: orphan result
      do_reset();
      force_orphan = 1'b1;
      @(negedge clk);
      chk("t5_drain", 64'(mul_release), 64'd1);
      chk("t5_rv", 64'(rsp_valid), 64'd0);
      tick(); force_orphan = 1'b0;
      @(negedge clk);
      chk("t5_err", 64'(err_orphan), 64'd1);
      tick(); tick();
      @(negedge clk);
      chk("t5_sticky", 64'(err_orphan), 64'd1);

      // 6: reset while issuing with two in flight
      do_reset();
      out_en = 1'b0; req_valid = 4'b0011;
      for (int c = 0; c < 5; c++) tick();
      rst = 1'b1; req_valid = '0;
      @(negedge clk);
      chk("t6_pre_inflight", 64'(inflight), 64'd3);
      chk("t6_pre_newdata", 64'(mul_new_data), 64'd1);
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("t6_inflight", 64'(inflight), 64'd0);
      chk("t6_newdata", 64'(mul_new_data), 64'd0);
      chk("t6_mul_a", 64'(mul_a), 64'd0);
      chk("t6_err", 64'(err_orphan), 64'd0);
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
